// File: rtl/ppe_pkg.sv
// rtl/ppe_pkg.sv - shared constants and types for the spiking PE stream block
// Purpose: opcode values, packet field positions and the PE state enum used
//          by ppe_stream and ppe_weight_rf.
// Ports:   none (package).
package ppe_pkg;

  // Packet opcodes
  localparam logic [3:0] OP_WEIGHT   = 4'd0;
  localparam logic [3:0] OP_INPUT    = 4'd1;
  localparam logic [3:0] OP_PSUM     = 4'd2;
  localparam logic [3:0] OP_TIMESTEP = 4'd15;

  // 33-bit packet layout: {addr, opcode, payload}
  localparam int PKT_W    = 33;
  localparam int ADDR_MSB = 32;
  localparam int ADDR_LSB = 29;
  localparam int OP_MSB   = 28;
  localparam int OP_LSB   = 25;
  localparam int PAY_MSB  = 24;
  localparam int PAY_LSB  = 0;

  // Result payload layout: {ts[3:0], col[4:0], psum[15:0]}
  localparam int OUT_TS_LSB  = 21;
  localparam int OUT_COL_LSB = 16;

  // Weight bytes carried by one WEIGHT packet
  localparam int WR_BYTES = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/ppe_weight_rf.sv
// rtl/ppe_weight_rf.sv - FILTER_W x 8-bit weight register file with auto-incrementing write pointer
// Purpose: holds the filter row; each write stores three bytes at wptr..wptr+2
//          (indices past the filter are dropped) and advances wptr by three,
//          returning it to 0 once it passes the end of the filter.
// Ports:   clk, reset (sync, active-high)
//          wr_en, wr_bytes[23:0]  - three-byte write, byte 0 goes to w[wptr]
//          rd_idx[4:0], rd_data   - combinational read, 0 for out-of-range index
module ppe_weight_rf
  import ppe_pkg::*;
#(
  parameter int FILTER_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [23:0] wr_bytes,
  input  logic [4:0]  rd_idx,
  output logic [7:0]  rd_data
);

  localparam int PTR_W = 6;

  logic [7:0]       w_q [FILTER_W];
  logic [7:0]       w_d [FILTER_W];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] wptr_inc;

  assign wptr_inc = wptr_q + PTR_W'(WR_BYTES);

  always_comb begin
    logic [PTR_W-1:0] off;
    w_d    = w_q;
    wptr_d = wptr_q;
    off    = '0;
    if (wr_en) begin
      for (int j = 0; j < FILTER_W; j++) begin
        off = PTR_W'(j) - wptr_q;
        if (PTR_W'(j) >= wptr_q && off < PTR_W'(WR_BYTES)) begin
          w_d[j] = wr_bytes[{off[1:0], 3'b000} +: 8];
        end
      end
      wptr_d = (wptr_inc >= PTR_W'(FILTER_W)) ? '0 : wptr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < FILTER_W; j++) w_q[j] <= '0;
      wptr_q <= '0;
    end else begin
      w_q    <= w_d;
      wptr_q <= wptr_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < FILTER_W; j++) begin
      if (rd_idx == 5'(j)) rd_data = w_q[j];
    end
  end

endmodule

// File: rtl/ppe_stream.sv
// rtl/ppe_stream.sv - packet-driven spiking 1-D convolution processing element
// Purpose: accepts WEIGHT/INPUT/TIMESTEP packets addressed to MY_ADDR, runs a
//          serial MAC over each output column of the spike row and emits one
//          partial-sum packet per column to DEST_ADDR.
// Ports:   clk, reset (sync, active-high)
//          in_valid/in_ready/in_data[32:0]    - command packet input
//          out_valid/out_ready/out_data[32:0] - partial-sum packet output
//          err_opcode                         - sticky unknown-opcode flag
module ppe_stream
  import ppe_pkg::*;
#(
  parameter int         FILTER_W  = 5,
  parameter int         IFMAP_W   = 25,
  parameter int         PSUM_W    = 13,
  parameter logic [3:0] MY_ADDR   = 4'd5,
  parameter logic [3:0] DEST_ADDR = 4'd9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PKT_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  out_data,
  output logic              err_opcode
);

  localparam int OUT_W = IFMAP_W - FILTER_W + 1;

  state_e              state_q, state_d;
  logic [IFMAP_W-1:0]  spikes_q, spikes_d;
  logic [4:0]          col_q, col_d;
  logic [4:0]          k_q, k_d;
  logic [PSUM_W-1:0]   acc_q, acc_d;
  logic [7:0]          term_q, term_d;
  logic [3:0]          ts_q, ts_d;
  logic                err_q, err_d;

  logic [3:0]          pkt_addr, pkt_op;
  logic [PAY_MSB:0]    pkt_pay;
  logic                pkt_mine;
  logic                out_fire;
  logic                last_tap;
  logic                last_col;
  logic [7:0]          w_k;
  logic [5:0]          tap;
  logic [IFMAP_W-1:0]  spikes_sh;

  assign pkt_addr = in_data[ADDR_MSB:ADDR_LSB];
  assign pkt_op   = in_data[OP_MSB:OP_LSB];
  assign pkt_pay  = in_data[PAY_MSB:PAY_LSB];
  assign pkt_mine = in_valid && in_ready && (pkt_addr == MY_ADDR);
  assign out_fire = out_valid && out_ready;
  assign last_tap = (k_q == 5'(FILTER_W));
  assign last_col = (col_q == 5'(OUT_W - 1));

  // Taps past the end of the row shift in zeros, so no bounds check is needed.
  assign tap       = {1'b0, col_q} + {1'b0, k_q};
  assign spikes_sh = spikes_q >> tap;

  ppe_weight_rf #(.FILTER_W(FILTER_W)) u_weight_rf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (pkt_mine && (pkt_op == OP_WEIGHT)),
    .wr_bytes (pkt_pay[23:0]),
    .rd_idx   (k_q),
    .rd_data  (w_k)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      spikes_q <= '0;
      col_q    <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      term_q   <= '0;
      ts_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      spikes_q <= spikes_d;
      col_q    <= col_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      term_q   <= term_d;
      ts_q     <= ts_d;
      err_q    <= err_d;
    end
  end

  // Next state. MAC runs FILTER_W+1 cycles: the selected weight is registered
  // in term_q and added one cycle later, so k==FILTER_W is the drain step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pkt_mine && (pkt_op == OP_INPUT)) state_d = MAC;
      MAC:     if (last_tap) state_d = EMIT;
      EMIT:    if (out_fire) state_d = last_col ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_comb begin
    spikes_d = spikes_q;
    col_d    = col_q;
    k_d      = k_q;
    acc_d    = acc_q;
    term_d   = term_q;
    ts_d     = ts_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pkt_mine) begin
          case (pkt_op)
            OP_WEIGHT: ;
            OP_INPUT: begin
              spikes_d = pkt_pay[IFMAP_W-1:0];
              col_d    = '0;
              k_d      = '0;
              acc_d    = '0;
              term_d   = '0;
            end
            OP_TIMESTEP: ts_d = ts_q + 4'd1;
            default:     err_d = 1'b1;
          endcase
        end
      end
      MAC: begin
        acc_d  = acc_q + PSUM_W'(term_q);
        term_d = (!last_tap && spikes_sh[0]) ? w_k : 8'd0;
        k_d    = k_q + 5'd1;
      end
      EMIT: begin
        if (out_fire && !last_col) begin
          col_d  = col_q + 5'd1;
          k_d    = '0;
          acc_d  = '0;
          term_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs: everything in out_data is frozen while in EMIT, so it holds
  // steady under backpressure without a separate output register.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == EMIT);
    err_opcode = err_q;
    out_data   = '0;
    if (state_q == EMIT) begin
      out_data = {DEST_ADDR, OP_PSUM, ts_q, col_q, 16'(acc_q)};
    end
  end

endmodule

// File: doc/ppe_stream.md
PPE_STREAM -- requirements
Module: ppe_stream

Interface
REQ-001 Parameter FILTER_W, default 5, number of 8-bit filter weights per row (1..24).
REQ-002 Parameter IFMAP_W, default 25, spike bits per input row (FILTER_W..25); OUT_W = IFMAP_W-FILTER_W+1.
REQ-003 Parameter PSUM_W, default 13, accumulator width (must be ≤16).
REQ-004 Parameter MY_ADDR, default 4'd5, address this PE accepts; DEST_ADDR, default 4'd9, address stamped on outputs.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1, rising-edge clock.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port in_valid, input, 1, in_data holds a packet.
REQ-009 Port in_ready, output, 1, PE accepts a packet this cycle.
REQ-010 Port in_data, input, 33, packet: [32:29] addr, [28:25] opcode, [24:0] payload.
REQ-011 Port out_valid, output, 1, out_data holds a partial-sum packet.
REQ-012 Port out_ready, input, 1, downstream accepts out_data.
REQ-013 Port out_data, output, 33, result packet.
REQ-014 Port err_opcode, output, 1, sticky flag: unknown opcode received.

Function
REQ-015 Transfer occurs on a rising edge where valid && ready; in_ready = 1 only in state IDLE.
REQ-016 Packets with addr != MY_ADDR SHALL be consumed and discarded with no state change.
REQ-017 Opcode 0 (WEIGHT): bytes [7:0],[15:8],[23:16] load w[wptr],w[wptr+1],w[wptr+2]; indices ≥FILTER_W discarded; wptr += 3, wrapping to 0 once ≥FILTER_W.
REQ-018 Opcode 1 (INPUT): latch payload[IFMAP_W-1:0] as spikes, col=0, k=0, acc=0, go MAC.
REQ-019 Opcode 15 (TIMESTEP): ts = ts+1 (4-bit, wraps 15→0); stay IDLE.
REQ-020 Any other opcode: consumed, ignored, err_opcode set until reset.
REQ-021 MAC: each cycle acc += spikes[col+k] ? w[k] : 0, k++; after k=FILTER_W-1 go EMIT.
REQ-022 acc unsigned PSUM_W bits, wraps modulo 2^PSUM_W.
REQ-023 EMIT: out_valid=1, out_data = {DEST_ADDR, 4'd2, ts[3:0], col[4:0], acc zero-extended to 16}.
REQ-024 out_data SHALL be stable while out_valid && !out_ready.
REQ-025 On EMIT transfer: if col=OUT_W-1 go IDLE, else col++, k=0, acc=0, go MAC.
REQ-026 Latency: first out_valid high exactly FILTER_W+1 cycles after the INPUT accept edge; each further result FILTER_W+1 cycles after previous transfer when out_ready held high.
REQ-027 Weights persist across INPUT rows and timesteps until overwritten or reset.

Reset
REQ-028 On reset: state IDLE, in_ready=1 next cycle, out_valid=0, out_data=0, err_opcode=0, w[*]=0, wptr=0, ts=0, col=k=acc=0.
REQ-029 Reset mid-MAC or mid-EMIT SHALL abort the row; no partial result is emitted afterwards.

Structure
REQ-030 Shared package ppe_pkg SHALL hold opcode constants (OP_WEIGHT=0, OP_INPUT=1, OP_PSUM=2, OP_TIMESTEP=15), packet field bit positions, and the state enum {IDLE, MAC, EMIT}.
REQ-031 One sub-module, ppe_weight_rf (FILTER_W×8 register file with wptr and 3-byte write port), is natural.

Verification
REQ-032 Weights packets {3,2,1},{0,5,4} then INPUT spikes bit i = i%2 -> 21 outputs, psums alternate 6,9,6,9,…, col 0..20, ts=0, opcode 2, addr 9.
REQ-033 Same weights, INPUT bit i = (i+1)%2 after TIMESTEP -> psums 9,6,9,…, ts field=1.
REQ-034 All-ones spikes, out_ready low 10 cycles at col 3 -> out_data held constant, psum 15 each, no result lost or duplicated.
REQ-035 Packet with addr 4'd6 and opcode 3 packet to addr 5 -> first produces nothing, second sets err_opcode, weights unchanged.
REQ-036 Assert reset during MAC of col 7 -> out_valid 0, in_ready 1 after reset, next INPUT with zero weights yields psum 0.
